// File: rtl/tcore_mem_arbiter.sv
// tcore_mem_arbiter: shares one external memory port between I-cache and D-cache traffic.
// One transaction in flight at a time. Simultaneous requests are granted round-robin.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   ic_req_*/ic_uncached_i               I-cache request (valid held until ready pulse)
//   ic_res_valid_o/ic_res_data_o         I-cache response pulse and held block
//   dc_req_*/dc_uncached_i/dc_rw_*       D-cache request, write data and access size
//   dc_res_valid_o/dc_res_data_o         D-cache response pulse and held block
//   mem_req_*                            memory request pulse; address, data, byte strobe held
//   mem_res_valid_i/mem_res_data_i       memory response, only honoured while waiting
module tcore_mem_arbiter #(
    parameter int XLEN = 32,
    parameter int BLK_SIZE = 128,
    localparam int STRB = BLK_SIZE / 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_uncached_i,
    output logic                ic_req_ready_o,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_data_o,
    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_uncached_i,
    input  logic                dc_rw_i,
    input  logic [1:0]          dc_rw_size_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    output logic                dc_req_ready_o,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_data_o,
    output logic                mem_req_valid_o,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    output logic [STRB-1:0]     mem_req_rw_o,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_data_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e                r_state, w_next;
    logic                  r_last_dc, r_src_dc;
    logic [XLEN-1:0]       r_addr, w_addr;
    logic [BLK_SIZE-1:0]   r_data, r_ic_res, r_dc_res;
    logic [STRB-1:0]       r_strb, w_strb, w_unc_strb;
    logic                  w_grant, w_grant_dc;
    always_comb begin
        w_grant    = ic_req_valid_i | dc_req_valid_i;
        // on a tie the source that was not granted last wins
        w_grant_dc = dc_req_valid_i & (~ic_req_valid_i | ~r_last_dc);
        w_addr     = w_grant_dc
                   ? (dc_uncached_i ? dc_req_addr_i : {dc_req_addr_i[XLEN-1:4], 4'b0})
                   : (ic_uncached_i ? ic_req_addr_i : {ic_req_addr_i[XLEN-1:4], 4'b0});
        // aligned shifts silently truncate misaligned uncached accesses
        w_unc_strb = dc_rw_size_i == 2'd1 ? STRB'(1) << dc_req_addr_i[3:0]
                   : dc_rw_size_i == 2'd2 ? STRB'(3) << {dc_req_addr_i[3:1], 1'b0}
                   : dc_rw_size_i == 2'd3 ? STRB'(15) << {dc_req_addr_i[3:2], 2'b00}
                   : '0;
        w_strb     = (w_grant_dc & dc_rw_i) ? (dc_uncached_i ? w_unc_strb : '1) : '0;
        w_next     = r_state == IDLE  ? (w_grant ? ISSUE : IDLE)
                   : r_state == ISSUE ? WAIT
                   : r_state == WAIT  ? (mem_res_valid_i ? RESP : WAIT)
                   : IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_last_dc <= 1'b1;
            r_src_dc  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            r_ic_res  <= '0;
            r_dc_res  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_grant) begin
                r_src_dc <= w_grant_dc;
                r_addr   <= w_addr;
                r_data   <= w_grant_dc ? dc_req_data_i : '0;
                r_strb   <= w_strb;
            end
            if (r_state == ISSUE) r_last_dc <= r_src_dc;
            if (r_state == WAIT && mem_res_valid_i && !r_src_dc) r_ic_res <= mem_res_data_i;
            if (r_state == WAIT && mem_res_valid_i && r_src_dc) r_dc_res <= mem_res_data_i;
        end
    end
    assign ic_req_ready_o  = r_state == ISSUE & ~r_src_dc;
    assign dc_req_ready_o  = r_state == ISSUE & r_src_dc;
    assign mem_req_valid_o = r_state == ISSUE;
    assign ic_res_valid_o  = r_state == RESP & ~r_src_dc;
    assign dc_res_valid_o  = r_state == RESP & r_src_dc;
    assign ic_res_data_o   = r_ic_res;
    assign dc_res_data_o   = r_dc_res;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_data_o  = r_data;
    assign mem_req_rw_o    = r_strb;
endmodule

// File: tb/tb_tcore_mem_arbiter.sv
// tb_tcore_mem_arbiter: scoreboard bench for the I/D memory arbiter.
module tb_tcore_mem_arbiter;
    logic         clk_i = 0, rst_ni = 0;
    logic         ic_req_valid_i = 0, ic_uncached_i = 0, ic_req_ready_o, ic_res_valid_o;
    logic [31:0]  ic_req_addr_i = 0;
    logic [127:0] ic_res_data_o;
    logic         dc_req_valid_i = 0, dc_uncached_i = 0, dc_rw_i = 0, dc_req_ready_o, dc_res_valid_o;
    logic [1:0]   dc_rw_size_i = 0;
    logic [31:0]  dc_req_addr_i = 0;
    logic [127:0] dc_req_data_i = 0, dc_res_data_o;
    logic         mem_req_valid_o, mem_res_valid_i = 0;
    logic [31:0]  mem_req_addr_o;
    logic [127:0] mem_req_data_o, mem_res_data_i = 0;
    logic [15:0]  mem_req_rw_o;

    tcore_mem_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_uncached_i(ic_uncached_i),
        .ic_req_ready_o(ic_req_ready_o), .ic_res_valid_o(ic_res_valid_o), .ic_res_data_o(ic_res_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i), .dc_uncached_i(dc_uncached_i),
        .dc_rw_i(dc_rw_i), .dc_rw_size_i(dc_rw_size_i), .dc_req_data_i(dc_req_data_i),
        .dc_req_ready_o(dc_req_ready_o), .dc_res_valid_o(dc_res_valid_o), .dc_res_data_o(dc_res_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_rw_o(mem_req_rw_o), .mem_res_valid_i(mem_res_valid_i), .mem_res_data_i(mem_res_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]  addr;
        logic [15:0]  strb;
        logic [127:0] data;
    } req_t;

    req_t         q_ic_req[$], q_dc_req[$], m_r;
    logic [127:0] q_ic_res[$], q_dc_res[$];
    bit           grant_log[$];
    int           errors = 0, checks = 0, outstanding = 0, res_pulses = 0, cyc = 0, mres_cyc = 0;
    bit           last_dc = 1, prev_ic = 0, prev_dc = 0, m_g, m_exp_g;
    int           mem_delay = 0;
    bit           mem_auto = 1, use_fixed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_strb(bit unc, bit rw, logic [1:0] sz, logic [31:0] a);
        int o = int'(a % 16);
        if (!rw) return 16'h0;
        if (!unc) return 16'hFFFF;
        case (sz)
            2'd1: return 16'h1 << o;
            2'd2: return 16'h3 << (o / 2 * 2);
            2'd3: return 16'hF << (o / 4 * 4);
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk_i) cyc++;

    // monitor: pops expectations whenever the DUT presents a request or a response
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            last_dc = 1; outstanding = 0; prev_ic = 0; prev_dc = 0;
        end else begin
            if (mem_res_valid_i) mres_cyc = cyc;
            if (mem_req_valid_o || ic_req_ready_o || dc_req_ready_o) begin
                chk("issue_handshake", {126'd0, mem_req_valid_o, ic_req_ready_o ^ dc_req_ready_o}, 128'd3);
                m_g = dc_req_ready_o;
                m_exp_g = (prev_ic && prev_dc) ? !last_dc : prev_dc;
                chk("grant_src", m_g, m_exp_g);
                chk("no_overlap", outstanding, 0);
                outstanding++;
                last_dc = m_g;
                grant_log.push_back(m_g);
                if ((m_g ? q_dc_req.size() : q_ic_req.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: got grant to %s expected no request", m_g ? "dc" : "ic");
                end else begin
                    m_r = m_g ? q_dc_req.pop_front() : q_ic_req.pop_front();
                    chk("mem_addr", mem_req_addr_o, m_r.addr);
                    chk("mem_strb", mem_req_rw_o, m_r.strb);
                    if (m_g) chk("mem_data", mem_req_data_o, m_r.data);
                end
            end
            if (ic_res_valid_o || dc_res_valid_o) begin
                res_pulses++;
                outstanding--;
                chk("res_one_hot", ic_res_valid_o & dc_res_valid_o, 0);
                chk("res_latency", cyc - mres_cyc, 1);
                if ((dc_res_valid_o ? q_dc_res.size() : q_ic_res.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_res: got %s response expected none", dc_res_valid_o ? "dc" : "ic");
                end else if (dc_res_valid_o) chk("dc_res_data", dc_res_data_o, q_dc_res.pop_front());
                else chk("ic_res_data", ic_res_data_o, q_ic_res.pop_front());
            end
            prev_ic = ic_req_valid_i;
            prev_dc = dc_req_valid_i;
        end
    end

    // memory model: answers each request after mem_delay cycles (random 1..4 when 0)
    initial begin
        bit           g;
        int           d;
        logic [127:0] v;
        forever begin
            @(negedge clk_i);
            if (rst_ni && mem_auto && mem_req_valid_o) begin
                g = dc_req_ready_o;
                d = mem_delay != 0 ? mem_delay : int'($urandom_range(1, 4));
                v = use_fixed ? {16{8'hA5}} : {$urandom(), $urandom(), $urandom(), $urandom()};
                repeat (d) @(posedge clk_i);
                #1;
                mem_res_data_i = v;
                mem_res_valid_i = 1;
                if (g) q_dc_res.push_back(v); else q_ic_res.push_back(v);
                @(posedge clk_i);
                #1 mem_res_valid_i = 0;
            end
        end
    end

    task automatic wait_ready(input bit d, output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(d ? dc_req_ready_o : ic_req_ready_o) && n < 400);
        if (!(d ? dc_req_ready_o : ic_req_ready_o)) begin
            checks++; errors++;
            $display("FAIL %s_ready_timeout: got no ready after %0d cycles expected one", d ? "dc" : "ic", n);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic ic_req(input logic [31:0] a, input bit unc, output int lat);
        req_t r;
        r.addr = unc ? a : a / 16 * 16;
        r.strb = 0;
        r.data = 0;
        @(posedge clk_i);
        #1;
        q_ic_req.push_back(r);
        ic_req_addr_i = a; ic_uncached_i = unc; ic_req_valid_i = 1;
        wait_ready(0, lat);
        ic_req_valid_i = 0;
    endtask

    task automatic dc_req(input logic [31:0] a, input bit unc, input bit rw, input logic [1:0] sz,
                          input logic [127:0] wd, output int lat);
        req_t r;
        r.addr = unc ? a : a / 16 * 16;
        r.strb = exp_strb(unc, rw, sz, a);
        r.data = wd;
        @(posedge clk_i);
        #1;
        q_dc_req.push_back(r);
        dc_req_addr_i = a; dc_uncached_i = unc; dc_rw_i = rw; dc_rw_size_i = sz; dc_req_data_i = wd;
        dc_req_valid_i = 1;
        wait_ready(1, lat);
        dc_req_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((outstanding != 0 || q_ic_res.size() != 0 || q_dc_res.size() != 0) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", outstanding);
        end
        repeat (2) @(posedge clk_i);
    endtask

    initial begin
        int lat, snap;
        logic [127:0] wd;
        // T1: reset with random inputs
        repeat (6) begin
            @(posedge clk_i);
            #1;
            {ic_req_valid_i, ic_uncached_i, dc_req_valid_i, dc_uncached_i, dc_rw_i, mem_res_valid_i} = 6'($urandom());
            ic_req_addr_i = $urandom(); dc_req_addr_i = $urandom(); dc_rw_size_i = 2'($urandom());
            dc_req_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_res_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk_i);
            chk("rst_ctrl", {ic_req_ready_o, ic_res_valid_o, dc_req_ready_o, dc_res_valid_o, mem_req_valid_o}, 0);
            chk("rst_mem", {mem_req_addr_o, mem_req_rw_o, |mem_req_data_o}, 0);
            chk("rst_res", ic_res_data_o | dc_res_data_o, 0);
        end
        ic_req_valid_i = 0; dc_req_valid_i = 0; mem_res_valid_i = 0;
        @(posedge clk_i);
        #1 rst_ni = 1;
        repeat (3) begin
            @(negedge clk_i);
            chk("idle_quiet", {ic_req_ready_o, ic_res_valid_o, dc_req_ready_o, dc_res_valid_o, mem_req_valid_o}, 0);
        end
        // T3: tie straight after reset, both sources want two transactions
        grant_log.delete();
        mem_delay = 1;
        fork
            begin int l; ic_req(32'h0000_1000, 0, l); ic_req(32'h0000_2000, 0, l); end
            begin int l; dc_req(32'h0000_3000, 0, 0, 2'd3, 0, l); dc_req(32'h0000_4000, 0, 0, 2'd3, 0, l); end
        join
        drain();
        chk("tie_count", grant_log.size(), 4);
        if (grant_log.size() == 4)
            chk("tie_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
        // T2: cached I fetch, memory answers 3 cycles after the request
        mem_delay = 3; use_fixed = 1;
        ic_req(32'h8000_0014, 0, lat);
        chk("req_latency", lat, 2);
        drain();
        chk("ic_res_hold", ic_res_data_o, {16{8'hA5}});
        use_fixed = 0; mem_delay = 0;
        // T4: uncached stores; T5: writeback
        wd = {$urandom(), $urandom(), $urandom(), $urandom()};
        dc_req(32'h1000_0007, 1, 1, 2'd1, wd, lat);
        chk("byte_strb", mem_req_rw_o, 16'h0080);
        dc_req(32'h1000_0006, 1, 1, 2'd2, wd, lat);
        chk("half_strb", mem_req_rw_o, 16'h00C0);
        dc_req(32'h1000_000B, 1, 1, 2'd3, wd, lat);
        dc_req(32'h1000_0005, 1, 1, 2'd0, wd, lat);
        dc_req(32'h2000_003C, 0, 1, 2'd3, wd, lat);
        chk("wb_addr", mem_req_addr_o, 32'h2000_0030);
        chk("wb_strb", mem_req_rw_o, 16'hFFFF);
        drain();
        // random mixed traffic
        fork
            repeat (25) begin
                int l;
                repeat ($urandom_range(0, 5)) @(posedge clk_i);
                ic_req($urandom(), 1'($urandom()), l);
            end
            repeat (25) begin
                int l;
                repeat ($urandom_range(0, 5)) @(posedge clk_i);
                dc_req($urandom(), 1'($urandom()), 1'($urandom()), 2'($urandom()),
                       {$urandom(), $urandom(), $urandom(), $urandom()}, l);
            end
        join
        drain();
        // T6: reset while waiting, then a stale memory response
        mem_auto = 0;
        ic_req(32'h0000_0100, 0, lat);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        snap = res_pulses;
        mem_res_valid_i = 1;
        @(posedge clk_i);
        #1 mem_res_valid_i = 0;
        repeat (5) @(posedge clk_i);
        chk("stale_ignored", res_pulses - snap, 0);
        mem_auto = 1;
        ic_req(32'h0000_0204, 1, lat);
        drain();
        chk("post_reset_resp", res_pulses - snap, 1);
        chk("queues_empty", q_ic_req.size() + q_dc_req.size() + q_ic_res.size() + q_dc_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
